// File: rtl/enigma_pkg.sv
// Shared types and constants for the Enigma rotor stepping logic.
package enigma_pkg;

  localparam int unsigned LETTER_W    = 5;
  localparam int unsigned NUM_LETTERS = 26;

  typedef logic [LETTER_W-1:0] letter_t;

  localparam letter_t LastLetter = letter_t'(NUM_LETTERS - 1);

  typedef enum logic [1:0] {
    OpStep      = 2'b00,
    OpLoadPos   = 2'b01,
    OpLoadNotch = 2'b10,
    OpClear     = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    IdxRight   = 2'd0,
    IdxMiddle  = 2'd1,
    IdxLeft    = 2'd2,
    IdxInvalid = 2'd3
  } cmd_idx_e;

endpackage

// File: rtl/enigma_mod26_inc.sv
// Increment a letter value modulo 26 (25 wraps to 0).
module enigma_mod26_inc
  import enigma_pkg::*;
(
  input  letter_t val_i,
  output letter_t val_o
);

  always_comb begin
    val_o = (val_i >= LastLetter) ? '0 : val_i + letter_t'(1);
  end

endmodule

// File: rtl/enigma_stepper.sv
// Three-rotor Enigma stepping controller with double-step behaviour and a
// two-state command handshake (one command every two cycles).
module enigma_stepper
  import enigma_pkg::*;
#(
  parameter int unsigned NOTCH_L = 16,
  parameter int unsigned NOTCH_M = 4,
  parameter int unsigned NOTCH_R = 21
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [1:0]          cmd_idx,
  input  logic [LETTER_W-1:0] cmd_data,
  output logic [LETTER_W-1:0] pos_l,
  output logic [LETTER_W-1:0] pos_m,
  output logic [LETTER_W-1:0] pos_r,
  output logic                step_done,
  output logic                err
);

  typedef enum logic {StIdle, StDone} state_e;

  state_e  state_q, state_d;
  letter_t pos_l_q, pos_l_d, pos_m_q, pos_m_d, pos_r_q, pos_r_d;
  letter_t notch_l_q, notch_l_d, notch_m_q, notch_m_d, notch_r_q, notch_r_d;
  logic    err_q, err_d;

  letter_t pos_l_inc, pos_m_inc, pos_r_inc;
  logic    accept, operand_ok, carry_r, carry_m;

  enigma_mod26_inc u_inc_l (.val_i(pos_l_q), .val_o(pos_l_inc));
  enigma_mod26_inc u_inc_m (.val_i(pos_m_q), .val_o(pos_m_inc));
  enigma_mod26_inc u_inc_r (.val_i(pos_r_q), .val_o(pos_r_inc));

  assign cmd_ready  = rst_n & (state_q == StIdle);
  assign accept     = cmd_valid & cmd_ready;
  assign operand_ok = (cmd_data <= LastLetter) && (cmd_idx != IdxInvalid);
  // Notch hits use pre-step positions; a middle-notch hit moves both middle and left.
  assign carry_r    = (pos_r_q == notch_r_q);
  assign carry_m    = (pos_m_q == notch_m_q);

  always_comb begin
    state_d   = StIdle;
    pos_l_d   = pos_l_q;
    pos_m_d   = pos_m_q;
    pos_r_d   = pos_r_q;
    notch_l_d = notch_l_q;
    notch_m_d = notch_m_q;
    notch_r_d = notch_r_q;
    err_d     = err_q;
    if (accept) begin
      state_d = StDone;
      unique case (cmd_op_e'(cmd_op))
        OpStep: begin
          pos_r_d = pos_r_inc;
          if (carry_r || carry_m) pos_m_d = pos_m_inc;
          if (carry_m)            pos_l_d = pos_l_inc;
        end
        OpLoadPos: begin
          if (!operand_ok) begin
            err_d = 1'b1;
          end else begin
            case (cmd_idx_e'(cmd_idx))
              IdxRight:  pos_r_d = cmd_data;
              IdxMiddle: pos_m_d = cmd_data;
              IdxLeft:   pos_l_d = cmd_data;
              default:   ;
            endcase
          end
        end
        OpLoadNotch: begin
          if (!operand_ok) begin
            err_d = 1'b1;
          end else begin
            case (cmd_idx_e'(cmd_idx))
              IdxRight:  notch_r_d = cmd_data;
              IdxMiddle: notch_m_d = cmd_data;
              IdxLeft:   notch_l_d = cmd_data;
              default:   ;
            endcase
          end
        end
        OpClear: begin
          pos_l_d = '0;
          pos_m_d = '0;
          pos_r_d = '0;
          err_d   = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      pos_l_q   <= '0;
      pos_m_q   <= '0;
      pos_r_q   <= '0;
      notch_l_q <= letter_t'(NOTCH_L);
      notch_m_q <= letter_t'(NOTCH_M);
      notch_r_q <= letter_t'(NOTCH_R);
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_l_q   <= pos_l_d;
      pos_m_q   <= pos_m_d;
      pos_r_q   <= pos_r_d;
      notch_l_q <= notch_l_d;
      notch_m_q <= notch_m_d;
      notch_r_q <= notch_r_d;
      err_q     <= err_d;
    end
  end

  assign pos_l     = pos_l_q;
  assign pos_m     = pos_m_q;
  assign pos_r     = pos_r_q;
  assign step_done = (state_q == StDone);
  assign err       = err_q;

endmodule

// File: tb/tb_enigma_stepper.sv
// Directed table plus randomized commands checked against a rotor-stepping model.
module tb_enigma_stepper;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [1:0] cmd_idx;
  logic [4:0] cmd_data;
  logic [4:0] pos_l, pos_m, pos_r;
  logic       step_done;
  logic       err;

  int tests = 0;
  int fails = 0;

  // Model state: index 0 right, 1 middle, 2 left.
  int mpos[3];
  int mnotch[3];
  int merr;

  typedef struct {
    logic [1:0] op;
    logic [1:0] idx;
    logic [4:0] data;
    int         l;
    int         m;
    int         r;
    int         e;
  } vec_t;

  vec_t vecs[$];

  enigma_stepper #(.NOTCH_L(16), .NOTCH_M(4), .NOTCH_R(21)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_idx  (cmd_idx),
    .cmd_data (cmd_data),
    .pos_l    (pos_l),
    .pos_m    (pos_m),
    .pos_r    (pos_r),
    .step_done(step_done),
    .err      (err)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input int op, input int idx, input int data,
                              input int l, input int m, input int r, input int e);
    vec_t v;
    v.op = 2'(op); v.idx = 2'(idx); v.data = 5'(data);
    v.l = l; v.m = m; v.r = r; v.e = e;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int l, input int m, input int r,
                            input int e);
    check({tag, " pos_l"}, int'(pos_l), l);
    check({tag, " pos_m"}, int'(pos_m), m);
    check({tag, " pos_r"}, int'(pos_r), r);
    check({tag, " err"},   int'(err),   e);
  endtask

  task automatic model_reset();
    mpos   = '{0, 0, 0};
    mnotch = '{21, 4, 16};
    merr   = 0;
  endtask

  task automatic model_apply(input int op, input int idx, input int data);
    bit hit_r, hit_m;
    case (op)
      0: begin
        hit_r = (mpos[0] == mnotch[0]);
        hit_m = (mpos[1] == mnotch[1]);
        mpos[0] = (mpos[0] + 1) % 26;
        if (hit_r || hit_m) mpos[1] = (mpos[1] + 1) % 26;
        if (hit_m)          mpos[2] = (mpos[2] + 1) % 26;
      end
      1, 2: begin
        if (data > 25 || idx == 3) merr = 1;
        else if (op == 1)          mpos[idx] = data;
        else                       mnotch[idx] = data;
      end
      default: begin
        mpos = '{0, 0, 0};
        merr = 0;
      end
    endcase
  endtask

  // Called and returns at a negedge; issues one command and checks the handshake.
  task automatic do_cmd(input int op, input int idx, input int data);
    int n = 0;
    while (!cmd_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("ready before cmd", int'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_op    = 2'(op);
    cmd_idx   = 2'(idx);
    cmd_data  = 5'(data);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom_range(0, 3));
    cmd_idx   = 2'($urandom_range(0, 3));
    cmd_data  = 5'($urandom_range(0, 31));
    check("step_done pulse", int'(step_done), 1);
    check("ready low in done", int'(cmd_ready), 0);
    model_apply(op, idx, data);
    @(negedge clk);
    check("step_done one cycle", int'(step_done), 0);
  endtask

  initial begin
    int pulses;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_idx   = 2'd0;
    cmd_data  = 5'd0;
    model_reset();

    repeat (3) @(negedge clk);
    check("reset ready", int'(cmd_ready), 0);
    check("reset step_done", int'(step_done), 0);
    check_outs("reset", 0, 0, 0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready after release", int'(cmd_ready), 1);

    // op: 0 STEP, 1 LOAD_POS, 2 LOAD_NOTCH, 3 CLEAR; expected (l,m,r,err) after.
    vecs.push_back(mk(0, 0, 0,  0, 0, 1,  0));
    vecs.push_back(mk(1, 0, 21, 0, 0, 21, 0));
    vecs.push_back(mk(0, 0, 0,  0, 1, 22, 0));
    vecs.push_back(mk(0, 0, 0,  0, 1, 23, 0));
    vecs.push_back(mk(1, 1, 3,  0, 3, 23, 0));
    vecs.push_back(mk(1, 0, 21, 0, 3, 21, 0));
    vecs.push_back(mk(0, 0, 0,  0, 4, 22, 0));
    vecs.push_back(mk(0, 0, 0,  1, 5, 23, 0));
    vecs.push_back(mk(0, 0, 0,  1, 5, 24, 0));
    vecs.push_back(mk(3, 2, 9,  0, 0, 0,  0));
    vecs.push_back(mk(1, 0, 25, 0, 0, 25, 0));
    vecs.push_back(mk(1, 1, 7,  0, 7, 25, 0));
    vecs.push_back(mk(0, 0, 0,  0, 7, 0,  0));
    vecs.push_back(mk(2, 0, 0,  0, 7, 0,  0));
    vecs.push_back(mk(0, 0, 0,  0, 8, 1,  0));
    vecs.push_back(mk(1, 0, 26, 0, 8, 1,  1));
    vecs.push_back(mk(2, 3, 5,  0, 8, 1,  1));
    vecs.push_back(mk(1, 2, 31, 0, 8, 1,  1));
    vecs.push_back(mk(0, 0, 0,  0, 8, 2,  1));
    vecs.push_back(mk(3, 0, 0,  0, 0, 0,  0));
    vecs.push_back(mk(2, 0, 21, 0, 0, 0,  0));
    vecs.push_back(mk(1, 2, 25, 25, 0, 0, 0));
    vecs.push_back(mk(1, 1, 4,  25, 4, 0, 0));
    vecs.push_back(mk(0, 0, 0,  0, 5, 1,  0));

    foreach (vecs[i]) begin
      do_cmd(int'(vecs[i].op), int'(vecs[i].idx), int'(vecs[i].data));
      check_outs($sformatf("vec%0d", i), vecs[i].l, vecs[i].m, vecs[i].r, vecs[i].e);
    end

    // cmd_valid held high with STEP for six edges: only every other edge accepts.
    cmd_valid = 1'b1;
    cmd_op    = 2'd0;
    pulses    = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (step_done) pulses++;
    end
    cmd_valid = 1'b0;
    check("held valid pulses", pulses, 3);
    repeat (3) model_apply(0, 0, 0);
    check_outs("held valid", mpos[2], mpos[1], mpos[0], merr);
    check_outs("held valid const", 0, 5, 4, 0);

    // Reset asserted while in DONE.
    do_cmd(1, 3, 0);
    check("err set", int'(err), 1);
    cmd_valid = 1'b1;
    cmd_op    = 2'd0;
    @(posedge clk);
    @(negedge clk);
    check("done before reset", int'(step_done), 1);
    cmd_valid = 1'b0;
    rst_n     = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("reset in done step_done", int'(step_done), 0);
    check("reset in done ready", int'(cmd_ready), 0);
    check_outs("reset in done", 0, 0, 0, 0);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    check("ready after second release", int'(cmd_ready), 1);

    for (int i = 0; i < 300; i++) begin
      int op, idx, data;
      op = int'($urandom_range(0, 3));
      if (op == 3 && $urandom_range(0, 3) != 0) op = 0;
      idx  = int'($urandom_range(0, 3));
      data = ($urandom_range(0, 4) == 0) ? int'($urandom_range(26, 31))
                                         : int'($urandom_range(0, 25));
      do_cmd(op, idx, data);
      check_outs($sformatf("rand%0d", i), mpos[2], mpos[1], mpos[0], merr);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/enigma_stepper.md
ENIGMA_STEPPER -- requirements
Module: enigma_stepper

Interface
REQ-001 SHALL have parameter NOTCH_L, default 16 (Q): left-rotor turnover position.
REQ-002 SHALL have parameter NOTCH_M, default 4 (E): middle-rotor turnover position.
REQ-003 SHALL have parameter NOTCH_R, default 21 (V): right-rotor turnover position.
REQ-004 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port cmd_valid  in  1  command offered.
REQ-007 SHALL have port cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at a rising edge.
REQ-008 SHALL have port cmd_op  in  2  00 STEP, 01 LOAD_POS, 10 LOAD_NOTCH, 11 CLEAR.
REQ-009 SHALL have port cmd_idx  in  2  rotor select: 0 right, 1 middle, 2 left, 3 invalid.
REQ-010 SHALL have port cmd_data  in  5  letter value 0..25 for LOAD_POS/LOAD_NOTCH.
REQ-011 SHALL have ports pos_l, pos_m, pos_r  out  5 each  current rotor positions, registered, fed to the rotor path.
REQ-012 SHALL have port step_done  out  1  one-cycle pulse: positions updated by an accepted command.
REQ-013 SHALL have port err  out  1  sticky illegal-command flag.

Function
REQ-014 SHALL implement FSM states IDLE and DONE; cmd_ready = 1 only in IDLE and rst_n high.
REQ-015 SHALL, on acceptance in IDLE, update positions/notches at that same edge and enter DONE; step_done = 1 exactly while in DONE.
REQ-016 SHALL return DONE -> IDLE unconditionally after one cycle; throughput = one command per 2 cycles.
REQ-017 SHALL ignore cmd_valid, cmd_op, cmd_idx, cmd_data while in DONE.
REQ-018 SHALL, on STEP, evaluate all notch comparisons on pre-step values: right always steps; middle steps if pos_r==notch_r OR pos_m==notch_m; left steps if pos_m==notch_m.
REQ-019 SHALL increment modulo 26: 25 -> 0; no carry is generated by wrap alone.
REQ-020 SHALL, on LOAD_POS with cmd_data<=25 and cmd_idx<=2, write the selected position only.
REQ-021 SHALL, on LOAD_NOTCH with legal operands, write the selected rotor's runtime notch register.
REQ-022 SHALL, on LOAD_POS/LOAD_NOTCH with cmd_data>25 or cmd_idx==3, leave all state unchanged, set err, and still enter DONE (step_done pulses).
REQ-023 SHALL, on CLEAR, set all positions to 0 and clear err; notch registers unchanged.
REQ-024 SHALL hold err until reset or CLEAR.

Reset
REQ-025 SHALL, while rst_n low at a rising edge: pos_l/pos_m/pos_r = 0, notch registers = NOTCH_L/NOTCH_M/NOTCH_R, err = 0, state = IDLE, step_done = 0.
REQ-026 SHALL hold cmd_ready = 0 while rst_n low; cmd_ready = 1 in the first cycle after release.
REQ-027 SHALL, on reset asserted in DONE, abandon the pulse and apply REQ-025 at that edge.

Structure
REQ-028 SHALL take from shared package enigma_pkg: LETTER_W=5, NUM_LETTERS=26, cmd_op encodings, cmd_idx encodings, letter typedef.
REQ-029 SHALL use one sub-module enigma_mod26_inc (5-bit in, 5-bit out, 25 -> 0), instantiated three times.
REQ-030 SHALL contain no combinational path from cmd_* to any output.

Verification
REQ-031 SHALL cover: reset, STEP -> next cycle pos (l,m,r) = (0,0,1), step_done high exactly 1 cycle, cmd_ready low that cycle.
REQ-032 SHALL cover: LOAD_POS idx0=21, STEP -> (0,1,22); STEP -> (0,1,23).
REQ-033 SHALL cover double step: load (0,3,21); STEP -> (0,4,22); STEP -> (1,5,23); STEP -> (1,5,24).
REQ-034 SHALL cover wrap: load r=25, m=7; STEP -> (0,7,0); LOAD_NOTCH idx0=0 then STEP from r=0 -> m=8.
REQ-035 SHALL cover errors: LOAD_POS data 26 -> err=1, positions unchanged, step_done pulses; idx3 -> err stays 1; CLEAR -> (0,0,0), err=0.
REQ-036 SHALL cover flow control/reset: cmd_valid held high with STEP for 6 cycles -> exactly 3 steps; rst_n low during DONE -> next cycle all outputs at reset values.
